// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
//   req      : initiator request strobe; wr/address/data_in valid while high
//   wr       : 1 = write, 0 = read
//   address  : byte address
//   data_in  : write data
//   data_out : registered read data
//   ack      : one-cycle completion pulse
//   busy     : responder is not idle
//   erro     : error flag, valid with ack
interface mem_responder_if;
   logic        req;
   logic        wr;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ack;
   logic        busy;
   logic        erro;

   modport slave  (input  req, wr, address, data_in,
                   output data_out, ack, busy, erro);
   modport master (output req, wr, address, data_in,
                   input  data_out, ack, busy, erro);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed number of wait states per access.
// Ports:
//   i_clk   : single clock, rising edge
//   i_rst_n : asynchronous active-low reset; clears state, outputs and array
//   io_bus  : mem_responder_if slave side (req/wr/address/data_in in,
//             data_out/ack/busy/erro out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for req; request fields latched when req is seen
// WAIT   | counting WAIT_STATES cycles, incoming req ignored
// RESP   | ack high for this single cycle, then back to IDLE
module mem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   mem_responder_if.slave  io_bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic          r_wr;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_ack;
   logic          r_erro;
   logic [31:0]   r_dout;
   logic [31:0]   r_mem [DEPTH];

   logic          w_take;
   logic          w_commit;
   logic          w_cur_wr;
   logic [31:0]   w_cur_addr;
   logic [31:0]   w_cur_wdata;
   logic          w_err;
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.req) begin
               w_take    = 1'b1;
               w_cnt_nxt = 4'd0;
               if (WAIT_STATES == 0) begin
                  w_state_nxt = ST_RESP;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_RESP;
               w_commit    = 1'b1;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // With zero wait states the commit happens on the sampling edge itself,
   // so the live bus fields stand in for the not-yet-latched copies.
   assign w_cur_wr    = (r_state == ST_IDLE) ? io_bus.wr      : r_wr;
   assign w_cur_addr  = (r_state == ST_IDLE) ? io_bus.address : r_addr;
   assign w_cur_wdata = (r_state == ST_IDLE) ? io_bus.data_in : r_wdata;

   assign w_err = (w_cur_addr[1:0] != 2'b00) ||
                  ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH));
   assign w_idx = w_cur_addr[IDX_W+1:2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_wr    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_ack   <= 1'b0;
         r_erro  <= 1'b0;
         r_dout  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_commit;
         if (w_take) begin
            r_wr    <= io_bus.wr;
            r_addr  <= io_bus.address;
            r_wdata <= io_bus.data_in;
         end
         if (w_commit) begin
            r_erro <= w_err;
            if (w_err)
               r_dout <= 32'd0;
            else if (!w_cur_wr)
               r_dout <= r_mem[w_idx];
         end
      end
   end

   // Array is cleared by reset, so an aborted write can never land.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= 32'd0;
      end else if (w_commit && w_cur_wr && !w_err) begin
         r_mem[w_idx] <= w_cur_wdata;
      end
   end

   assign io_bus.data_out = r_dout;
   assign io_bus.ack      = r_ack;
   assign io_bus.erro     = r_erro;
   assign io_bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int WS  = 2;
   localparam int DEP = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   mem_responder_if bus ();
   mem_responder_if bus0 ();

   mem_responder #(.DEPTH(DEP), .WAIT_STATES(WS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   mem_responder #(.DEPTH(DEP), .WAIT_STATES(0)) dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus0)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // Transaction-level reference for the WS=2 instance: a request accepted on
   // edge k0 keeps the block busy through edge k0+WS, resolves on edge k0+WS
   // (ack visible after it) and the next request can be taken on edge k0+WS+2.
   int          cyc = 0;
   int          m_k0 = -100;
   int          m_next_ok = 0;
   logic        m_wr;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_mem [DEP];
   logic [31:0] m_dout;
   logic        m_erro;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; m_k0 = -100; m_next_ok = 0; m_dout = 0; m_erro = 0;
         for (int i = 0; i < DEP; i++) m_mem[i] = 0;
      end else begin
         cyc++;
         if (cyc >= m_next_ok && bus.req === 1'b1) begin
            m_k0 = cyc; m_next_ok = cyc + WS + 2;
            m_wr = bus.wr; m_addr = bus.address; m_wdata = bus.data_in;
         end
         if (cyc == m_k0 + WS) begin
            int idx;
            idx = int'(m_addr[31:2]);
            if (m_addr[1:0] != 2'b00 || idx >= DEP) begin
               m_dout = 0; m_erro = 1;
            end else if (m_wr) begin
               m_mem[idx] = m_wdata; m_erro = 0;
            end else begin
               m_dout = m_mem[idx]; m_erro = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic eb, ea;
      eb = (cyc >= m_k0) && (cyc <= m_k0 + WS);
      ea = (cyc == m_k0 + WS);
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("ack", 32'(bus.ack), 32'(ea));
      chk("data_out", bus.data_out, m_dout);
      chk("erro", 32'(bus.erro), 32'(m_erro));
   end

   task automatic drive(input bit sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         bus0.req = r; bus0.wr = w; bus0.address = a; bus0.data_in = d;
      end else begin
         bus.req = r; bus.wr = w; bus.address = a; bus.data_in = d;
      end
   endtask

   function automatic logic get_ack(input bit sel);
      return sel ? bus0.ack : bus.ack;
   endfunction

   // Starts aligned 2 time units after a rising edge; returns number of
   // edges after the sampling edge until ack is seen.
   task automatic do_txn(input bit sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [31:0] rd, output logic er);
      drive(sel, 1'b1, w, a, d);
      @(posedge clk); #2;
      drive(sel, 1'b0, w, a, d);
      lat = 0;
      while (get_ack(sel) !== 1'b1 && lat < 20) begin
         @(posedge clk); #2;
         lat++;
      end
      rd = sel ? bus0.data_out : bus.data_out;
      er = sel ? bus0.erro : bus.erro;
      @(posedge clk); #2;
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          n_ack, n_busy;

      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_dout", bus.data_out, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // write then read back
      do_txn(0, 1, 32'h10, 32'hDEADBEEF, lat, rd, er);
      chk("wr_lat", 32'(lat), 32'd2);
      do_txn(0, 0, 32'h10, 32'h0, lat, rd, er);
      chk("rd_lat", 32'(lat), 32'd2);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_erro", 32'(er), 32'd0);

      // misaligned and out-of-range reads
      do_txn(0, 0, 32'h102, 32'h0, lat, rd, er);
      chk("mis_erro", 32'(er), 32'd1);
      chk("mis_data", rd, 32'd0);
      do_txn(0, 0, 32'h100, 32'h0, lat, rd, er);
      chk("oor_erro", 32'(er), 32'd1);
      chk("oor_lat", 32'(lat), 32'd2);
      do_txn(0, 1, 32'h101, 32'h5555AAAA, lat, rd, er);
      chk("miswr_erro", 32'(er), 32'd1);
      do_txn(0, 0, 32'h0, 32'h0, lat, rd, er);
      chk("word0", rd, 32'd0);

      // reset during WAIT of a write aborts it
      do_txn(0, 0, 32'h10, 32'h0, lat, rd, er);
      chk("pre_rst_data", rd, 32'hDEADBEEF);
      drive(0, 1, 1, 32'h04, 32'h12345678);
      @(posedge clk); #2;
      drive(0, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_ack", 32'(bus.ack), 32'd0);
      chk("abort_dout", bus.data_out, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      do_txn(0, 0, 32'h04, 32'h0, lat, rd, er);
      chk("aborted_word", rd, 32'd0);
      chk("aborted_lat", 32'(lat), 32'd2);

      // bus changes during WAIT are ignored
      drive(0, 1, 1, 32'h20, 32'hA5A50001);
      @(posedge clk); #2;
      drive(0, 0, 1, 32'h24, 32'hBAD0BAD0);
      repeat (3) @(posedge clk);
      #2;
      do_txn(0, 0, 32'h20, 32'h0, lat, rd, er);
      chk("latched_wr", rd, 32'hA5A50001);
      do_txn(0, 0, 32'h24, 32'h0, lat, rd, er);
      chk("no_wr_24", rd, 32'd0);

      // back-to-back requests with req held high
      do_txn(0, 1, 32'h10, 32'h11111111, lat, rd, er);
      do_txn(0, 1, 32'h14, 32'h22222222, lat, rd, er);
      n_ack = 0; n_busy = 0;
      drive(0, 1, 0, 32'h10, 32'h0);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #2;
         drive(0, 1, 0, (i % 2 == 0) ? 32'h14 : 32'h10, 32'h0);
         @(negedge clk);
         if (bus.ack === 1'b1) n_ack++;
         if (bus.busy === 1'b1) n_busy++;
      end
      drive(0, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #2;
      chk("stream_acks", 32'(n_ack), 32'd4);
      chk("stream_busy", 32'(n_busy), 32'd12);

      // zero-wait-state instance
      do_txn(1, 1, 32'h08, 32'hCAFEF00D, lat, rd, er);
      chk("ws0_wr_lat", 32'(lat), 32'd0);
      do_txn(1, 0, 32'h08, 32'h0, lat, rd, er);
      chk("ws0_rd_lat", 32'(lat), 32'd0);
      chk("ws0_rd_data", rd, 32'hCAFEF00D);
      chk("ws0_idle", 32'(bus0.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
